// File: rtl/load_store_sequencer.sv
// load_store_sequencer: sequences core loads/stores onto a word-wide req/gnt/rvalid memory port
module load_store_sequencer #(
    parameter bit          SPLIT_EN    = 1'b1,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        core_req_valid_i,
    output logic        core_req_ready_o,
    input  logic        core_we_i,
    input  logic [2:0]  core_funct3_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    output logic        core_rsp_valid_o,
    output logic        core_rsp_err_o,
    output logic [31:0] core_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);
    typedef enum logic [2:0] {IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP} state_e;

    function automatic logic [2:0] size_of(input logic [2:0] f3);
        return f3[1] ? 3'd4 : f3[0] ? 3'd2 : 3'd1;
    endfunction

    function automatic logic crosses(input logic [2:0] f3, input logic [1:0] off);
        return ({1'b0, off} + size_of(f3)) > 3'd4;
    endfunction

    state_e      state_q, state_d;
    logic        we_q, we_d, err_q, err_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, beat0_q, beat0_d, rdata_q, rdata_d;
    logic [31:0] tmo_q, tmo_d;
    logic        in_illegal, split_q, timed_out;
    logic [4:0]  sh;
    logic [7:0]  lanes_q;
    logic [31:0] word_addr, rot_wdata, hi, lo, ld_w, ld_ext;

    assign in_illegal = core_funct3_i[1:0] == 2'b11 || (core_funct3_i[2] && (core_we_i || core_funct3_i[1]));
    assign split_q    = crosses(f3_q, addr_q[1:0]);
    assign lanes_q    = {4'b0, f3_q[1] ? 4'hF : f3_q[0] ? 4'h3 : 4'h1} << addr_q[1:0];
    assign sh         = {addr_q[1:0], 3'b000};
    assign word_addr  = {addr_q[31:2], 2'b00};
    assign rot_wdata  = 32'({wdata_q, wdata_q} >> (6'd32 - {1'b0, sh}));
    assign hi         = state_q == WAIT1 ? mem_rdata_i : '0;
    assign lo         = state_q == WAIT1 ? beat0_q : mem_rdata_i;
    assign ld_w       = 32'({hi, lo} >> sh);
    assign ld_ext     = f3_q[1] ? ld_w :
                        f3_q[0] ? {{16{~f3_q[2] & ld_w[15]}}, ld_w[15:0]} :
                                  {{24{~f3_q[2] & ld_w[7]}}, ld_w[7:0]};
    assign timed_out  = TIMEOUT_CYC != 0 && tmo_q == TIMEOUT_CYC - 1;

    assign core_req_ready_o = state_q == IDLE;
    assign core_rsp_valid_o = state_q == RESP;
    assign core_rsp_err_o   = core_rsp_valid_o & err_q;
    assign core_rdata_o     = core_rsp_valid_o ? rdata_q : '0;

    // State and transaction registers; reset aborts any transaction in flight
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            beat0_q <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            beat0_q <= beat0_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state, memory beat generation, load assembly and timeout handling
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        f3_d        = f3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        beat0_d     = beat0_q;
        tmo_d       = tmo_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        case (state_q)
            IDLE: if (core_req_valid_i) begin
                we_d    = core_we_i;
                f3_d    = core_funct3_i;
                addr_d  = core_addr_i;
                wdata_d = core_wdata_i;
                err_d   = in_illegal || (!SPLIT_EN && crosses(core_funct3_i, core_addr_i[1:0]));
                rdata_d = '0;
                state_d = err_d ? RESP : ISSUE0;
            end
            ISSUE0, ISSUE1: begin
                mem_req_o   = 1'b1;
                mem_we_o    = we_q;
                mem_addr_o  = state_q == ISSUE1 ? word_addr + 32'd4 : word_addr;
                mem_be_o    = state_q == ISSUE1 ? lanes_q[7:4] : lanes_q[3:0];
                mem_wdata_o = rot_wdata;
                if (mem_gnt_i) begin
                    tmo_d   = '0;
                    state_d = state_q == ISSUE1 ? WAIT1 : WAIT0;
                end
            end
            WAIT0, WAIT1: if (mem_rvalid_i) begin
                beat0_d = state_q == WAIT0 ? mem_rdata_i : beat0_q;
                rdata_d = we_q ? '0 : ld_ext;
                state_d = state_q == WAIT0 && split_q ? ISSUE1 : RESP;
            end else if (timed_out) begin
                err_d   = 1'b1;
                rdata_d = '0;
                state_d = RESP;
            end else begin
                tmo_d = tmo_q + 32'd1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule
